interrupt_sequencer: RTL
========================

Name: interrupt_sequencer

Overview:
Sequences reset, NMI and IRQ entry for the 6502 core. It takes over the address and data bus from the instruction decoder at instruction boundaries. It pushes PCH, PCL and P onto the stack, fetches the vector and loads the program counter. While it owns the bus, it holds the decoder off via busy.

Parameters:
RESET_VECTOR, 16'hFFFC, low-byte address of the reset vector
NMI_VECTOR, 16'hFFFA, low-byte address of the NMI vector
IRQ_VECTOR, 16'hFFFE, low-byte address of the IRQ vector
STACK_PAGE, 8'h01, high byte of the stack address

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
clk_enable  input  1  state and registers advance only when high
irq  input  1  level-sensitive interrupt request, active-high
nmi  input  1  non-maskable request, active-high, rising-edge triggered
i_flag  input  1  current interrupt-disable flag from the status register
at_boundary  input  1  decoder is about to enter opcode fetch
pc_in  input  16  current program counter
status_in  input  8  current processor status byte
sp_in  input  8  current stack pointer
data_in  input  8  external data bus, used for vector reads
busy  output  1  sequencer owns the bus; decoder must stall
addr  output  16  bus address while busy
data_out  output  8  bus write data
rw  output  1  1 = read, 0 = write
sp_dec  output  1  one-cycle pulse; SP register decrements on this enabled edge
pc_load  output  1  one-cycle pulse; PC loads pc_value
pc_value  output  16  {vec_hi, vec_lo}
set_i_flag  output  1  one-cycle pulse; sets the I flag
nmi_ack  output  1  pulse on entry to an NMI sequence
irq_ack  output  1  pulse on entry to an IRQ sequence

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Clock enable: all state changes are gated by clk_enable. Outputs are decoded from the state, so they hold while clk_enable is low.
- Reset values: state = S_VEC_LO, vector = RESET_VECTOR, nmi_pending = 0, nmi_prev = 1, vec_lo = vec_hi = 0.
- Outputs while rst is high: busy = 1, addr = 16'hFFFC, rw = 1. All pulses are 0, data_out = 0.
- NMI edge detect: nmi_prev <= nmi on each enabled edge. nmi_pending is set when nmi && !nmi_prev, and cleared on entry to S_PUSH_PCH with vector = NMI_VECTOR.
- Because nmi_prev resets to 1, an nmi held high through reset does not fire.
- S_IDLE: busy = 0, all outputs 0, rw = 1. If at_boundary is high:
  - nmi_pending high: go to S_PUSH_PCH with vector = NMI_VECTOR and pulse nmi_ack.
  - else irq && !i_flag: go to S_PUSH_PCH with vector = IRQ_VECTOR and pulse irq_ack.
  - NMI has priority over IRQ. With no request, or at_boundary low, stay in S_IDLE.
- S_PUSH_PCH: addr = {STACK_PAGE, sp_in}, data_out = pc_in[15:8], rw = 0, sp_dec = 1. Next state S_PUSH_PCL.
- S_PUSH_PCL: same as S_PUSH_PCH with data_out = pc_in[7:0]. Next state S_PUSH_P.
- S_PUSH_P: same as S_PUSH_PCH with data_out = status_in with bit4 (B) = 0 and bit5 = 1. Next state S_VEC_LO.
- S_VEC_LO: addr = vector, rw = 1. vec_lo <= data_in. Next state S_VEC_HI.
- S_VEC_HI: addr = vector + 1, rw = 1, vec_hi <= data_in, set_i_flag = 1. Next state S_LOAD_PC.
- S_LOAD_PC: pc_load = 1 with pc_value = {vec_hi, vec_lo}. Next state S_IDLE.
- busy = 1 in every state except S_IDLE.
- Latency: an interrupt takes 6 enabled cycles from acceptance to PC loaded. Reset takes 3 enabled cycles after rst deasserts.
- NMI hijack: a new NMI edge during an IRQ sequence, while the state is S_PUSH_PCH, S_PUSH_PCL or S_PUSH_P, switches vector to NMI_VECTOR. It also clears nmi_pending and pulses nmi_ack. Once in S_VEC_LO or later, the NMI stays pending and is taken at the next boundary.
- An IRQ deasserted mid-sequence does not abort the sequence. irq is sampled only in S_IDLE.
- rst asserted mid-sequence immediately forces the reset state. No pushes have effect after that point.
- Address arithmetic: vector + 1 wraps modulo 2^16. The stack address never carries out of STACK_PAGE.

Decomposition:
- inc/interrupt_defs.vh: state localparams (3 bits, S_IDLE..S_LOAD_PC), default vector constants, status bit indices for B and bit5. The I flag index comes from the existing status_register.vh.
- One sub-module: nmi_edge_detect (nmi_prev register, pending set/clear, clk_enable gating).

Test Plan:
- Reset, then release with memory FFFC=34, FFFD=12 -> addr FFFC, then FFFD; pc_load with pc_value 16'h1234 on the 3rd enabled cycle; busy falls after.
- IRQ with pc_in=8000, sp_in=FF, status_in=20, i_flag=0, boundary, vector bytes FFFE=00 / FFFF=90 -> writes 0x80@01FF, 0x00@01FE, 0x20@01FD (B cleared); reads FFFE, FFFF; set_i_flag pulse; pc_value 9000; irq_ack pulse.
- irq=1 with i_flag=1 -> stays in S_IDLE, busy=0. A rising edge on nmi then causes entry with addr FFFA on the vector read; nmi_ack pulses.
- NMI edge during S_PUSH_PCL of an IRQ sequence -> vector reads at FFFA/FFFB, no repeat NMI afterwards. Edge in S_VEC_HI -> second sequence starts at the next boundary.
- clk_enable toggled 1/0 throughout an IRQ sequence -> identical bus trace, each state held while disabled, each pulse seen exactly once per enabled edge.
- rst pulsed during S_PUSH_P -> addr FFFC immediately, busy=1, followed by a reset vector fetch. nmi held high across reset -> no NMI taken.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer_pkg : states, vector defaults and status helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_PCH = 3'd1,
        S_PUSH_PCL = 3'd2,
        S_PUSH_P   = 3'd3,
        S_VEC_LO   = 3'd4,
        S_VEC_HI   = 3'd5,
        S_LOAD_PC  = 3'd6
    } state_t;

    localparam logic [15:0] c_reset_vector = 16'hFFFC;
    localparam logic [15:0] c_nmi_vector   = 16'hFFFA;
    localparam logic [15:0] c_irq_vector   = 16'hFFFE;
    localparam logic [7:0]  c_stack_page   = 8'h01;

    localparam int unsigned c_b_bit    = 4;
    localparam int unsigned c_bit5_bit = 5;

    // Status byte as it is pushed by a hardware interrupt: B clear, bit 5 set.
    function automatic logic [7:0] pushed_status(input logic [7:0] status);
        logic [7:0] v;
        v             = status;
        v[c_b_bit]    = 1'b0;
        v[c_bit5_bit] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer_if : core-side bus and control bundle of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface interrupt_sequencer_if;

    logic        clk_enable;
    logic        irq;
    logic        nmi;
    logic        i_flag;
    logic        at_boundary;
    logic [15:0] pc_in;
    logic [7:0]  status_in;
    logic [7:0]  sp_in;
    logic [7:0]  data_in;
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        rw;
    logic        sp_dec;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        set_i_flag;
    logic        nmi_ack;
    logic        irq_ack;

    modport master (
        input  clk_enable, irq, nmi, i_flag, at_boundary,
        input  pc_in, status_in, sp_in, data_in,
        output busy, addr, data_out, rw, sp_dec, pc_load, pc_value,
        output set_i_flag, nmi_ack, irq_ack
    );

    modport slave (
        output clk_enable, irq, nmi, i_flag, at_boundary,
        output pc_in, status_in, sp_in, data_in,
        input  busy, addr, data_out, rw, sp_dec, pc_load, pc_value,
        input  set_i_flag, nmi_ack, irq_ack
    );

endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer_nmi_edge_detect : NMI rising-edge latch with clear
// Rev 1.0
// ----------------------------------------------------------------------------
module interrupt_sequencer_nmi_edge_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clk_enable,
    input  wire logic i_nmi,
    input  wire logic i_clear,
    output logic      o_rise,
    output logic      o_pending
);

    logic r_nmi_prev;
    logic r_pending;

    assign o_rise    = i_nmi & ~r_nmi_prev;
    assign o_pending = r_pending;

    // Previous level resets high so an NMI held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_prev <= 1'b1;
            r_pending  <= 1'b0;
        end else if (i_clk_enable) begin
            r_nmi_prev <= i_nmi;
            r_pending  <= (r_pending | o_rise) & ~i_clear;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer : reset/NMI/IRQ entry - stack pushes, vector fetch, PC load
// Rev 1.0
// ----------------------------------------------------------------------------
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = c_reset_vector,
    parameter logic [15:0] NMI_VECTOR   = c_nmi_vector,
    parameter logic [15:0] IRQ_VECTOR   = c_irq_vector,
    parameter logic [7:0]  STACK_PAGE   = c_stack_page
) (
    input  wire logic              clk,
    input  wire logic              rst,
    interrupt_sequencer_if.master  sif
);

    state_t      r_state;
    logic [15:0] r_vector;
    logic [7:0]  r_vec_lo;
    logic [7:0]  r_vec_hi;
    logic        r_nmi_ack;
    logic        r_irq_ack;

    logic        w_nmi_rise;
    logic        w_nmi_pending;
    logic        w_in_push;
    logic        w_take_nmi;
    logic        w_take_irq;
    logic        w_hijack;
    logic        w_nmi_clear;

    logic        w_busy;
    logic [15:0] w_addr;
    logic [7:0]  w_data_out;
    logic        w_rw;
    logic        w_sp_dec;
    logic        w_pc_load;
    logic        w_set_i_flag;

    interrupt_sequencer_nmi_edge_detect u_nmi_edge (
        .clk          (clk),
        .rst          (rst),
        .i_clk_enable (sif.clk_enable),
        .i_nmi        (sif.nmi),
        .i_clear      (w_nmi_clear),
        .o_rise       (w_nmi_rise),
        .o_pending    (w_nmi_pending)
    );

    assign w_in_push  = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) ||
                        (r_state == S_PUSH_P);
    assign w_take_nmi = (r_state == S_IDLE) && sif.at_boundary && w_nmi_pending;
    assign w_take_irq = (r_state == S_IDLE) && sif.at_boundary && !w_nmi_pending &&
                        sif.irq && !sif.i_flag;
    // An NMI arriving while an IRQ is still pushing redirects the vector fetch.
    assign w_hijack   = w_in_push && (r_vector != NMI_VECTOR) &&
                        (w_nmi_pending || w_nmi_rise);
    assign w_nmi_clear = w_take_nmi || w_hijack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_VEC_LO;
            r_vector  <= RESET_VECTOR;
            r_vec_lo  <= 8'h00;
            r_vec_hi  <= 8'h00;
            r_nmi_ack <= 1'b0;
            r_irq_ack <= 1'b0;
        end else if (sif.clk_enable) begin
            r_nmi_ack <= 1'b0;
            r_irq_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take_nmi) begin
                        r_state   <= S_PUSH_PCH;
                        r_vector  <= NMI_VECTOR;
                        r_nmi_ack <= 1'b1;
                    end else if (w_take_irq) begin
                        r_state   <= S_PUSH_PCH;
                        r_vector  <= IRQ_VECTOR;
                        r_irq_ack <= 1'b1;
                    end
                end
                S_PUSH_PCH: r_state <= S_PUSH_PCL;
                S_PUSH_PCL: r_state <= S_PUSH_P;
                S_PUSH_P:   r_state <= S_VEC_LO;
                S_VEC_LO: begin
                    r_vec_lo <= sif.data_in;
                    r_state  <= S_VEC_HI;
                end
                S_VEC_HI: begin
                    r_vec_hi <= sif.data_in;
                    r_state  <= S_LOAD_PC;
                end
                S_LOAD_PC: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
            if (w_hijack) begin
                r_vector  <= NMI_VECTOR;
                r_nmi_ack <= 1'b1;
            end
        end
    end

    always_comb begin
        w_busy       = 1'b1;
        w_addr       = 16'h0000;
        w_data_out   = 8'h00;
        w_rw         = 1'b1;
        w_sp_dec     = 1'b0;
        w_pc_load    = 1'b0;
        w_set_i_flag = 1'b0;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
                w_addr   = {STACK_PAGE, sif.sp_in};
                w_rw     = 1'b0;
                w_sp_dec = 1'b1;
                if (r_state == S_PUSH_PCH)      w_data_out = sif.pc_in[15:8];
                else if (r_state == S_PUSH_PCL) w_data_out = sif.pc_in[7:0];
                else                            w_data_out = pushed_status(sif.status_in);
            end
            S_VEC_LO: w_addr = r_vector;
            S_VEC_HI: begin
                w_addr       = r_vector + 16'd1;
                w_set_i_flag = 1'b1;
            end
            S_LOAD_PC: w_pc_load = 1'b1;
            default: w_busy = 1'b1;
        endcase
    end

    assign sif.busy       = w_busy;
    assign sif.addr       = w_addr;
    assign sif.data_out   = w_data_out;
    assign sif.rw         = w_rw;
    assign sif.sp_dec     = w_sp_dec;
    assign sif.pc_load    = w_pc_load;
    assign sif.pc_value   = {r_vec_hi, r_vec_lo};
    assign sif.set_i_flag = w_set_i_flag;
    assign sif.nmi_ack    = r_nmi_ack;
    assign sif.irq_ack    = r_irq_ack;

endmodule
`default_nettype wire
